// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse-train transmitter: FSM state encoding and
// default counter widths.
`timescale 1ns/1ps

package pulse_train_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero; load wins over enable.
`timescale 1ns/1ps

module load_down_counter #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Count register: reload, or step down until the terminal count is reached.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train transmitter with registered waveform, edge strobes,
// busy and done.
//
// state | meaning
// IDLE  | waiting for start
// HIGH  | signal_out high, phase counter running down from high_cycles-1
// LOW   | signal_out low, phase counter running down from low_cycles-1
// FIN   | one-cycle done strobe; a new start is accepted here
`timescale 1ns/1ps

module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] pulse_num,
  output logic             signal_out,
  output logic             rise_flag,
  output logic             fall_flag,
  output logic             busy,
  output logic             done
);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_low;

  logic r_signal_out;
  logic r_rise_flag;
  logic r_fall_flag;
  logic r_busy;
  logic r_done;

  logic             w_accept;
  logic             w_zero_cfg;
  logic             w_ph_load;
  logic [CNT_W-1:0] w_ph_val;
  logic             w_ph_en;
  logic [CNT_W-1:0] w_ph_cnt;
  logic             w_ph_zero;
  logic             w_pl_load;
  logic [NUM_W-1:0] w_pl_val;
  logic             w_pl_en;
  logic [NUM_W-1:0] w_pl_cnt;
  logic             w_pl_zero;
  logic             w_unused;

  logic w_sig_nxt;
  logic w_rise_nxt;
  logic w_fall_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  // FIN reports busy=0, so a start there is taken just like in IDLE.
  assign w_accept   = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_FIN));
  assign w_zero_cfg = (high_cycles == '0) || (low_cycles == '0) || (pulse_num == '0);

  // The counters are only observed through their zero flags.
  assign w_unused = ^{w_ph_cnt, w_pl_cnt};

  load_down_counter #(.W(CNT_W)) u_phase_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (w_ph_load),
    .load_val  (w_ph_val),
    .en        (w_ph_en),
    .cnt       (w_ph_cnt),
    .zero      (w_ph_zero)
  );

  load_down_counter #(.W(NUM_W)) u_pulse_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (w_pl_load),
    .load_val  (w_pl_val),
    .en        (w_pl_en),
    .cnt       (w_pl_cnt),
    .zero      (w_pl_zero)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched phase lengths, reused for every reload during the train.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_high <= '0;
      r_low  <= '0;
    end else if (w_accept) begin
      r_high <= high_cycles;
      r_low  <= low_cycles;
    end
  end

  // Next-state, counter control and next output values.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_load   = 1'b0;
    w_ph_val    = '0;
    w_ph_en     = 1'b0;
    w_pl_load   = 1'b0;
    w_pl_val    = '0;
    w_pl_en     = 1'b0;

    case (r_state)
      ST_IDLE, ST_FIN: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_zero_cfg) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_HIGH;
            w_ph_load   = 1'b1;
            w_ph_val    = high_cycles - 1'b1;
            w_pl_load   = 1'b1;
            w_pl_val    = pulse_num - 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_ph_load   = 1'b1;
          w_pl_load   = 1'b1;
        end else if (w_ph_zero) begin
          w_state_nxt = ST_LOW;
          w_ph_load   = 1'b1;
          w_ph_val    = r_low - 1'b1;
        end else begin
          w_ph_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_ph_load   = 1'b1;
          w_pl_load   = 1'b1;
        end else if (w_ph_zero) begin
          if (!w_pl_zero) begin
            w_state_nxt = ST_HIGH;
            w_pl_en     = 1'b1;
            w_ph_load   = 1'b1;
            w_ph_val    = r_high - 1'b1;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end else begin
          w_ph_en = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_sig_nxt  = (w_state_nxt == ST_HIGH);
    w_busy_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW);
    w_done_nxt = (w_state_nxt == ST_FIN);
    w_rise_nxt = (w_state_nxt == ST_HIGH) && (r_state != ST_HIGH);
    w_fall_nxt = r_signal_out && (w_state_nxt != ST_HIGH);
  end

  // Registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_signal_out <= 1'b0;
      r_rise_flag  <= 1'b0;
      r_fall_flag  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_signal_out <= w_sig_nxt;
      r_rise_flag  <= w_rise_nxt;
      r_fall_flag  <= w_fall_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign signal_out = r_signal_out;
  assign rise_flag  = r_rise_flag;
  assign fall_flag  = r_fall_flag;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Programmable pulse-train transmitter; the generating end of the edge-flag interface used by the team's edge detectors.
On a start strobe it drives a single-bit output with pulse_num pulses, each high_cycles high then low_cycles low.
It reports its own edges as one-cycle rise_flag and fall_flag strobes, and raises busy while running and done at completion.
It feeds GPIO or stimulus paths that downstream edge detectors sample.

Parameters:
CNT_W, 16, width of the high_cycles/low_cycles phase-length inputs and the phase counter
NUM_W, 8, width of pulse_num and the pulse counter

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; accepted only when busy=0
abort  input  1  terminate the running train
high_cycles  input  CNT_W  high-phase length in clocks; sampled at accepted start
low_cycles  input  CNT_W  low-phase length in clocks; sampled at accepted start
pulse_num  input  NUM_W  number of pulses; sampled at accepted start
signal_out  output  1  generated waveform, registered
rise_flag  output  1  one-cycle strobe in the first cycle signal_out=1 of each pulse
fall_flag  output  1  one-cycle strobe in the first cycle signal_out=0 after a high phase
busy  output  1  train in progress, registered
done  output  1  one-cycle strobe on normal completion

Behaviour:
- Clock and reset: reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- Reset values: every output is 0, the FSM is in IDLE, and all counters are 0. Assertion mid-train takes effect immediately; no done is issued.
- FSM states are IDLE, HIGH, LOW and FIN. All outputs are registered.
- IDLE:
  - start=1 and abort=0 latches high_cycles, low_cycles and pulse_num.
  - If any latched value is 0, go to FIN: no edges are generated and done is the only response.
  - Otherwise go to HIGH. In the next cycle signal_out=1, rise_flag=1 and busy=1.
- HIGH: the phase counter is loaded with high_cycles-1 and counts down. At 0, go to LOW. In the next cycle signal_out=0 and fall_flag=1.
- LOW: the phase counter is loaded with low_cycles-1. At 0:
  - If the pulse counter holds remaining pulses, decrement it and go to HIGH, with rise_flag=1 in the next cycle.
  - After the last pulse, go to FIN.
- The final low phase is always completed in full, so every period is exactly high_cycles+low_cycles.
- FIN lasts one cycle. In it done=1 and busy=0, and the FSM returns to IDLE. start is accepted in this cycle: busy=0 means accepted.
- Latency: an accepted start at cycle t gives signal_out=1 at t+1. The zero-config case gives done at t+1.
- start while busy=1 is ignored; no queuing.
- Input changes while busy have no effect, because only latched copies are used.
- abort=1 in HIGH or LOW:
  - The next cycle has signal_out=0 and busy=0, and the FSM goes to IDLE. No done is issued.
  - fall_flag=1 in that cycle only if signal_out was 1.
  - abort has priority over a phase/pulse terminal count in the same cycle.
- abort in IDLE or FIN has no effect on outputs. abort and start together in IDLE: abort wins and start is dropped.
- rise_flag and fall_flag are never asserted in the same cycle, and are never asserted while busy=0, except the abort fall_flag.
- Maximum lengths: high_cycles=2^CNT_W-1 and pulse_num=2^NUM_W-1 are supported with no counter wrap.
- A downstream two-flop edge detector on signal_out reports each edge exactly 1 cycle after this block's own flag.

Decomposition:
- Shared package pulse_train_pkg holds the FSM state encoding constants (IDLE, HIGH, LOW, FIN, 2-bit) and the default CNT_W and NUM_W.
- One natural sub-module, load_down_counter (parameter W), has inputs load, load_val and en, and outputs cnt and zero.
- It is instantiated twice: as the phase counter (W=CNT_W) and as the pulse counter (W=NUM_W).

Test Plan:
1. high=3, low=2, num=2, start at cycle 0:
   - signal_out=1 at cycles 1-3 and 6-8, and 0 at 4-5 and 9-10.
   - rise_flag at cycles 1 and 6; fall_flag at cycles 4 and 9.
   - busy at cycles 1-10; done at cycle 11.
2. high=1, low=1, num=4, start at cycle 0 -> signal_out toggles 1,0 over cycles 1-8, with 4 rise_flags and 4 fall_flags; done at cycle 9.
3. Zero config:
   - num=0 with start -> done at cycle 1; signal_out, rise_flag, fall_flag and busy stay 0.
   - Repeat with high=0, and with low=0 -> same result.
4. high=5, low=5, num=3, abort at cycle 3 (mid-high) -> signal_out=0, fall_flag=1 and busy=0 at cycle 4; no done. A start at cycle 5 launches a new train at cycle 6.
5. high=4, low=4, num=2:
   - A second start with num=9 and high=1 at cycle 2 is ignored; the train is unchanged and done occurs at cycle 17.
   - A start in the done cycle (17) is accepted, giving rise_flag at cycle 18.
6. Reset mid-operation:
   - sys_rst_n is pulled low asynchronously mid-LOW -> all outputs are 0 before the next clock edge; no done after release.
   - Loopback check: an edge-detector instance on signal_out shows its flags exactly 1 cycle after rise_flag and fall_flag.
